// File: rtl/sync_fifo.sv
// Synchronous FIFO with arbitrary (non-power-of-two) depth, occupancy flags,
// sticky overflow/underflow and a choice of registered or fall-through read data.
module sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_DEPTH = 8,
  parameter int AF_LEVEL      = 6,
  parameter int AE_LEVEL      = 1,
  parameter int FWFT          = 0,
  localparam int CW           = $clog2(ADDRESS_DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_INC,
  input  logic                  CLR_ERR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [CW-1:0]         COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int PW = (ADDRESS_DEPTH > 2) ? $clog2(ADDRESS_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(ADDRESS_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(ADDRESS_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [ADDRESS_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] head;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign FULL         = (count == DEPTH_C);
  assign EMPTY        = (count == '0);
  assign ALMOST_FULL  = (count >= AF_C);
  assign ALMOST_EMPTY = (count <= AE_C);
  assign COUNT        = count;
  assign OVERFLOW     = overflow;
  assign UNDERFLOW    = underflow;

  assign wr_ok = WR_INC & ~FULL;
  assign rd_ok = RD_INC & ~EMPTY;
  assign head  = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error on the same edge as a clear takes priority.
      overflow  <= (WR_INC & FULL)  | (overflow  & ~CLR_ERR);
      underflow <= (RD_INC & EMPTY) | (underflow & ~CLR_ERR);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= WR_DATA;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign RD_DATA  = EMPTY ? '0 : head;
      assign RD_VALID = ~EMPTY;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_ok;
          if (rd_ok) rd_data_q <= head;
        end
      end

      assign RD_DATA  = rd_data_q;
      assign RD_VALID = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Drives a depth-8 registered-read FIFO and a depth-5 fall-through FIFO with the
// same directed stimulus and checks both against a queue-based model every cycle.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_inc = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_inc = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] rd_data8, rd_data5;
  logic       rd_valid8, rd_valid5;
  logic       full8, full5, empty8, empty5;
  logic       af8, af5, ae8, ae5;
  logic [3:0] count8;
  logic [2:0] count5;
  logic       ovf8, ovf5, unf8, unf5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .ADDRESS_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u8 (
    .CLK(clk), .RST(rst), .WR_INC(wr_inc), .WR_DATA(wr_data), .RD_INC(rd_inc),
    .CLR_ERR(clr_err), .RD_DATA(rd_data8), .RD_VALID(rd_valid8), .FULL(full8),
    .EMPTY(empty8), .ALMOST_FULL(af8), .ALMOST_EMPTY(ae8), .COUNT(count8),
    .OVERFLOW(ovf8), .UNDERFLOW(unf8)
  );

  sync_fifo #(.DATA_WIDTH(8), .ADDRESS_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u5 (
    .CLK(clk), .RST(rst), .WR_INC(wr_inc), .WR_DATA(wr_data), .RD_INC(rd_inc),
    .CLR_ERR(clr_err), .RD_DATA(rd_data5), .RD_VALID(rd_valid5), .FULL(full5),
    .EMPTY(empty5), .ALMOST_FULL(af5), .ALMOST_EMPTY(ae5), .COUNT(count5),
    .OVERFLOW(ovf5), .UNDERFLOW(unf5)
  );

  // Model configuration: index 0 = u8, index 1 = u5.
  function automatic int dep(input int k); return (k == 0) ? 8 : 5; endfunction
  function automatic int afl(input int k); return (k == 0) ? 6 : 4; endfunction
  function automatic int ael(input int k); return 1; endfunction
  function automatic bit fwm(input int k); return k != 0; endfunction

  logic [7:0] mq [2][$];
  int e_rd [2] = '{0, 0};
  bit e_rv [2] = '{1'b0, 1'b0};
  bit e_ovf [2] = '{1'b0, 1'b0};
  bit e_unf [2] = '{1'b0, 1'b0};
  int m_n;
  bit m_full, m_empty, m_wok, m_rok;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        e_rd[k] = 0; e_rv[k] = 1'b0; e_ovf[k] = 1'b0; e_unf[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_n     = mq[k].size();
        m_full  = (m_n == dep(k));
        m_empty = (m_n == 0);
        m_wok   = wr_inc && !m_full;
        m_rok   = rd_inc && !m_empty;
        if (!fwm(k)) begin
          e_rv[k] = m_rok;
          if (m_rok) e_rd[k] = mq[k][0];
        end
        if (m_rok) void'(mq[k].pop_front());
        if (m_wok) mq[k].push_back(wr_data);
        e_ovf[k] = (wr_inc && m_full)  || (e_ovf[k] && !clr_err);
        e_unf[k] = (rd_inc && m_empty) || (e_unf[k] && !clr_err);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input int rd, input bit rv, input bit full,
                           input bit empty, input bit af, input bit ae, input int cnt,
                           input bit ovf, input bit unf);
    int n;
    string p;
    n = mq[k].size();
    p = (k == 0) ? "d8" : "d5";
    chk({p, "_count"}, cnt, n);
    chk({p, "_full"}, int'(full), int'(n == dep(k)));
    chk({p, "_empty"}, int'(empty), int'(n == 0));
    chk({p, "_almost_full"}, int'(af), int'(n >= afl(k)));
    chk({p, "_almost_empty"}, int'(ae), int'(n <= ael(k)));
    chk({p, "_overflow"}, int'(ovf), int'(e_ovf[k]));
    chk({p, "_underflow"}, int'(unf), int'(e_unf[k]));
    if (fwm(k)) begin
      chk({p, "_rd_valid"}, int'(rv), int'(n != 0));
      if (n != 0) chk({p, "_rd_data"}, rd, int'(mq[k][0]));
    end else begin
      chk({p, "_rd_valid"}, int'(rv), int'(e_rv[k]));
      chk({p, "_rd_data"}, rd, e_rd[k]);
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, int'(rd_data8), rd_valid8, full8, empty8, af8, ae8, int'(count8), ovf8, unf8);
    check_dut(1, int'(rd_data5), rd_valid5, full5, empty5, af5, ae5, int'(count5), ovf5, unf5);
  end

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
    wr_inc = w; wr_data = d; rd_inc = r; clr_err = c;
    @(posedge clk);
    #1;
    wr_inc = 1'b0; rd_inc = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", int'(count8), 0);
    chk("reset_empty", int'(empty8), 1);
    chk("reset_almost_empty", int'(ae8), 1);
    chk("reset_rd_data", int'(rd_data8), 0);
    #2 rst = 1'b1;

    // Fill depth 8, then drain in order with one-cycle valid pulses.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
    chk("fill_count", int'(count8), 8);
    chk("fill_full", int'(full8), 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_rd_data", int'(rd_data8), (8'h11 * (i + 1)) & 8'hFF);
      chk("drain_rd_valid", int'(rd_valid8), 1);
    end
    chk("drain_empty", int'(empty8), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("valid_pulse_end", int'(rd_valid8), 0);
    chk("drain_hold_data", int'(rd_data8), 8'h88);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Full with simultaneous write and read, then error clear and set-wins.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("full_wr_rd_count", int'(count8), 7);
    chk("full_wr_rd_overflow", int'(ovf8), 1);
    chk("full_wr_rd_head", int'(rd_data8), 8'hB0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clear_overflow", int'(ovf8), 0);
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b1);
    chk("set_wins_overflow", int'(ovf8), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("after_drain_last", int'(rd_data8), 8'hC0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Empty with simultaneous write and read.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("empty_wr_rd_count", int'(count8), 1);
    chk("empty_wr_rd_underflow", int'(unf8), 1);
    chk("empty_wr_rd_valid", int'(rd_valid8), 0);
    chk("fwft_empty_wr_rd_data", int'(rd_data5), 8'hA5);
    chk("fwft_empty_wr_rd_valid", int'(rd_valid5), 1);
    chk("fwft_empty_wr_rd_underflow", int'(unf5), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Almost-empty / almost-full thresholds.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
      if (i == 0) chk("ae_at_1", int'(ae8), 1);
      if (i == 1) chk("ae_at_2", int'(ae8), 0);
      if (i == 4) chk("af_at_5", int'(af8), 0);
      if (i == 5) chk("af_at_6", int'(af8), 1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_reset_count", int'(count8), 4);

    // Asynchronous reset between edges discards contents.
    #1 rst = 1'b0;
    #1;
    chk("async_count", int'(count8), 0);
    chk("async_empty", int'(empty8), 1);
    chk("async_full", int'(full8), 0);
    chk("async_almost_full", int'(af8), 0);
    chk("async_rd_valid", int'(rd_valid8), 0);
    chk("async_rd_data", int'(rd_data8), 0);
    chk("async_overflow_d5", int'(ovf5), 0);
    chk("async_count_d5", int'(count5), 0);
    #1 rst = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_reset_fwft_data", int'(rd_data5), 8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_reset_rd_data", int'(rd_data8), 8'h3C);
    chk("post_reset_rd_valid", int'(rd_valid8), 1);

    // Interleaved traffic wraps the depth-5 pointers several times.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("wrap_d5_count", int'(count5), 4);
    chk("wrap_d5_head", int'(rd_data5), 8'h78);
    chk("wrap_d8_last", int'(rd_data8), 8'h77);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("final_d8_last", int'(rd_data8), 8'h7B);
    chk("final_d5_empty", int'(empty5), 1);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: SYNC_FIFO

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits.
REQ-002 SHALL have parameter ADDRESS_DEPTH, default 8, meaning the number of entries (any value >= 2, not restricted to a power of two).
REQ-003 SHALL have parameter AF_LEVEL, default 6, meaning the ALMOST_FULL threshold (1..ADDRESS_DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 1, meaning the ALMOST_EMPTY threshold (0..ADDRESS_DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, meaning read mode (0 = registered read, 1 = first-word-fall-through).
REQ-006 SHALL use a derived count width CW = clog2(ADDRESS_DEPTH+1).
REQ-007 SHALL provide port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL provide port RST, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL provide port WR_INC, input, 1 bit: write request.
REQ-010 SHALL provide port WR_DATA, input, DATA_WIDTH bits: write data.
REQ-011 SHALL provide port RD_INC, input, 1 bit: read/pop request.
REQ-012 SHALL provide port CLR_ERR, input, 1 bit: clears the sticky error flags.
REQ-013 SHALL provide port RD_DATA, output, DATA_WIDTH bits: read data.
REQ-014 SHALL provide port RD_VALID, output, 1 bit: RD_DATA is valid.
REQ-015 SHALL provide ports FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY, each output, 1 bit: occupancy flags.
REQ-016 SHALL provide port COUNT, output, CW bits: current occupancy.
REQ-017 SHALL provide ports OVERFLOW and UNDERFLOW, each output, 1 bit: sticky error flags.

Function
REQ-018 SHALL accept a write when WR_INC=1 and FULL=0, sampling FULL before the clock edge.
REQ-019 SHALL accept a read when RD_INC=1 and EMPTY=0, sampling EMPTY before the clock edge.
REQ-020 SHALL store an accepted write at wr_ptr and advance wr_ptr.
REQ-021 SHALL advance rd_ptr on an accepted read.
REQ-022 SHALL wrap both pointers from ADDRESS_DEPTH-1 to 0.
REQ-023 SHALL update COUNT each edge as follows: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 SHALL decode the flags from the registered COUNT: FULL = (COUNT == ADDRESS_DEPTH); EMPTY = (COUNT == 0); ALMOST_FULL = (COUNT >= AF_LEVEL); ALMOST_EMPTY = (COUNT <= AE_LEVEL).
REQ-025 SHALL, with FULL=1 and WR_INC and RD_INC both high, accept the read, reject the write, and leave COUNT at ADDRESS_DEPTH-1.
REQ-026 SHALL, with EMPTY=1 and WR_INC and RD_INC both high, accept the write, reject the read, and leave COUNT at 1.
REQ-027 SHALL set OVERFLOW on a rejected write and set UNDERFLOW on a rejected read.
REQ-028 SHALL hold OVERFLOW and UNDERFLOW until CLR_ERR=1; when a clear and a new error occur on the same edge, set SHALL win.
REQ-029 SHALL, in FWFT=0 mode, register the head word into RD_DATA on an accepted read and pulse RD_VALID high for exactly the following cycle (1-cycle latency).
REQ-030 SHALL, in FWFT=0 mode, hold RD_DATA at its last value otherwise.
REQ-031 SHALL, in FWFT=1 mode, present the head word on RD_DATA whenever EMPTY=0, with RD_VALID = ~EMPTY; the accepted read pops it and the next word appears after the edge.
REQ-032 SHALL make a word written at edge N visible (EMPTY deasserted, FWFT data valid) after edge N; there is no write-to-read bypass within a cycle.
REQ-033 SHALL keep the contents of the storage array unaffected by rejected requests.

Reset
REQ-034 SHALL, on RST=0 and regardless of CLK, set wr_ptr=0, rd_ptr=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, RD_DATA=0, RD_VALID=0, OVERFLOW=0, UNDERFLOW=0.
REQ-035 SHALL leave the storage array unreset, with contents unobservable until rewritten.
REQ-036 SHALL discard all stored words on a reset asserted mid-operation; the first read after reset release SHALL return the first word written after release.

Verification
REQ-037 SHALL cover this scenario: DEPTH=8, FWFT=0; write 0x11..0x88 -> FULL=1 and COUNT=8 after the 8th edge; then 8 reads -> RD_DATA 0x11..0x88 in order, each with a one-cycle RD_VALID pulse, and EMPTY=1.
REQ-038 SHALL cover this scenario: DEPTH=5 (non-power-of-two); 12 interleaved write/read pairs -> pointers wrap at 4->0, data order is preserved, and COUNT stays within 0..5.
REQ-039 SHALL cover this scenario: FIFO full with WR_INC=RD_INC=1 -> COUNT=7, OVERFLOW=1, and the head is popped; then CLR_ERR=1 -> OVERFLOW=0 on the next edge.
REQ-040 SHALL cover this scenario: FIFO empty with WR_INC=RD_INC=1 and WR_DATA=0xA5 -> COUNT=1, UNDERFLOW=1, RD_VALID=0; with FWFT=1, RD_DATA=0xA5 and RD_VALID=1 after the edge.
REQ-041 SHALL cover this scenario: AF_LEVEL=6, AE_LEVEL=1; fill to 6 -> ALMOST_FULL rises at COUNT=6 and ALMOST_EMPTY falls at COUNT=2.
REQ-042 SHALL cover this scenario: RST pulsed low between edges with COUNT=4 -> all outputs at reset values immediately; a write of 0x3C and a read after release -> RD_DATA=0x3C.
